// File: rtl/enc16_pkg.sv
// Shared widths and bit-vector helpers for the 16-line priority arbiter.
package enc16_pkg;

    localparam int N_REQ  = 16;
    localparam int CODE_W = 4;
    localparam int CNT_W  = 5;

    function automatic logic [N_REQ-1:0] onehot16(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] popcnt16(input logic [N_REQ-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/enc16_arb_if.sv
// Request/offer bundle between a requester-side master and the arbiter.
interface enc16_arb_if;
    import enc16_pkg::*;

    logic [N_REQ-1:0]  req;
    logic              ready;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic [N_REQ-1:0]  pend;
    logic [CNT_W-1:0]  pend_cnt;

    modport master (output req, output ready, input code, input valid, input pend, input pend_cnt);
    modport slave  (input req, input ready, output code, output valid, output pend, output pend_cnt);

endinterface

// File: rtl/enc16_arb_enc4x2.sv
// Combinational 4-to-2 priority encoder, highest set bit wins; used as a tree node.
module enc4x2 (
    input  logic [3:0] i_in,
    output logic [1:0] o_code,
    output logic       o_any
);

    // Highest-index-first selection; all-zero input encodes as 0.
    always_comb begin
        o_code = 2'd0;
        if (i_in[3]) begin
            o_code = 2'd3;
        end else if (i_in[2]) begin
            o_code = 2'd2;
        end else if (i_in[1]) begin
            o_code = 2'd1;
        end else begin
            o_code = 2'd0;
        end
    end

    assign o_any = |i_in;

endmodule

// File: rtl/enc16_arb.sv
// 16-line fixed-priority arbiter: sticky pending vector, registered offer held
// stable until accepted.
module enc16_arb
    import enc16_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    enc16_arb_if.slave   bus
);

    logic [N_REQ-1:0]  r_pend;
    logic [CNT_W-1:0]  r_pend_cnt;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;

    logic              w_accept;
    logic              w_load;
    logic [N_REQ-1:0]  w_clr;
    logic [N_REQ-1:0]  w_pend_next;
    logic [1:0]        w_leaf_code [4];
    logic [3:0]        w_leaf_any;
    logic [1:0]        w_hi_code;
    logic [1:0]        w_lo_code;
    logic              w_any;

    assign w_accept = r_valid & bus.ready;
    assign w_load   = ~r_valid | w_accept;
    assign w_clr    = w_accept ? onehot16(r_code) : {N_REQ{1'b0}};
    // A same-cycle request on the accepted bit re-arms it because req is ORed after the clear.
    assign w_pend_next = (r_pend & ~w_clr) | bus.req;

    for (genvar g = 0; g < 4; g++) begin : g_leaf
        enc4x2 u_leaf (
            .i_in   (w_pend_next[4*g +: 4]),
            .o_code (w_leaf_code[g]),
            .o_any  (w_leaf_any[g])
        );
    end

    enc4x2 u_root (
        .i_in   (w_leaf_any),
        .o_code (w_hi_code),
        .o_any  (w_any)
    );

    assign w_lo_code = w_leaf_code[w_hi_code];

    // Pending vector always tracks; the offer only reloads when idle or just accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= {N_REQ{1'b0}};
            r_pend_cnt <= {CNT_W{1'b0}};
            r_code     <= {CODE_W{1'b0}};
            r_valid    <= 1'b0;
        end else begin
            r_pend     <= w_pend_next;
            r_pend_cnt <= popcnt16(w_pend_next);
            if (w_load) begin
                r_valid <= w_any;
                r_code  <= {w_hi_code, w_lo_code};
            end
        end
    end

    assign bus.code     = r_code;
    assign bus.valid    = r_valid;
    assign bus.pend     = r_pend;
    assign bus.pend_cnt = r_pend_cnt;

endmodule
